vis_display: RTL and testbench
==============================

// Module: vis_display
// PURPOSE
// - Board-level visualiser: shows the 8-bit switch value SW as a decimal number
//   on a 4-digit multiplexed common-anode 7-segment display, and mirrors it on the LEDs.
// - Conversion is binary -> 4-digit BCD, exported on dat for probing.
// - Sits at top level, directly on the 50 MHz board clock, switches, BTN0, LEDs and display.
// PARAMETERS
// - DIV_W  default 16  width of the refresh counter; digit index = cnt[DIV_W-1:DIV_W-2]
//   (DIV_W=16 gives about 763 Hz per digit at 50 MHz; a bench uses DIV_W=4)
// PORTS
// - F50MHz  in   1  system clock, 50 MHz; every register updates on its rising edge
// - BTN0    in   1  reset: synchronous, active-low (0 = reset, sampled on the F50MHz rising edge)
// - SW      in   8  unsigned binary value to display (0..255)
// - AN      out  4  digit anodes, active-low one-hot; AN[0] = rightmost digit
// - SEG     out  8  segments, active-low {dp,g,f,e,d,c,b,a}; SEG[7] = dp
// - LED     out  8  mirror of the registered switch value
// - dat     out 16  BCD of the registered SW {thousands,hundreds,tens,units}; dat[15:12] is always 0
// BEHAVIOUR
// - Reset (BTN0=0 at a rising edge) sets: sw_q=0, dat=16'h0000, LED=8'h00, cnt=0,
//   AN=4'b1111, SEG=8'hFF. Reset overrides all other updates, including mid-scan.
// - Pipeline from SW:
//   - Edge 1: sw_q <= SW, LED <= SW.
//   - Edge 2: dat <= bcd(sw_q), computed combinationally (double-dabble or equivalent).
//   - So a SW change appears on LED after 1 edge and on dat after 2 edges.
// - BCD range: 8'hFF -> 16'h0255; 8'h00 -> 16'h0000. No overflow is possible.
// - Refresh counter: cnt increments by 1 every cycle and wraps modulo 2^DIV_W.
//   - idx = cnt[DIV_W-1:DIV_W-2] selects the digit.
//   - idx 0 -> AN 4'b1110 (dat[3:0]); 1 -> 4'b1101 (dat[7:4]);
//     2 -> 4'b1011 (dat[11:8]); 3 -> 4'b0111 (dat[15:12]).
// - AN and SEG are registered from idx and dat: one cycle behind idx. Exactly one AN bit is
//   low at any time outside reset.
// - Segment codes {g..a}, active-low: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12
//   6=7'h02 7=7'h78 8=7'h00 9=7'h10.
//   - Nibbles A..F never occur; if one does, all segments are blank (7'h7F).
// - SEG[7] (dp) is held at 1 (off).
// - A SW change mid-scan shows up on the next digit refresh. No glitch suppression is required.
// CONFIGURATION
// - Macro VIS_LEADING_ZERO_BLANK_EN:
//   - Defined: a zero digit is blanked (SEG=8'hFF, AN still driven) when every
//     more-significant digit is also zero. Digit 0 is never blanked.
//     Example: dat=16'h0009 shows only "9".
//   - Undefined: all four digits are always shown. Example: 16'h0009 shows "0009".
// TESTING
// - Reset: BTN0=0 for 2 edges -> AN=4'b1111, SEG=8'hFF, LED=8'h00, dat=16'h0000.
//   Then BTN0=1 -> AN becomes one-hot-low within 1 cycle.
// - Conversion: SW=8'h01/8'h09/8'h10/8'h1A/8'h1F/8'hFF
//   -> dat=16'h0001/0009/0016/0026/0031/0255, each 2 edges after the SW change;
//   LED = SW after 1 edge.
// - Scan (DIV_W=4): AN steps 1110->1101->1011->0111, each held 4 cycles, repeating.
// - Segments: SW=8'hFF, DIV_W=4 -> SEG=8'h92 while AN=1110, 8'h92 while AN=1101,
//   8'hA4 while AN=1011, and 8'hC0 while AN=0111 (8'hFF when VIS_LEADING_ZERO_BLANK_EN).
// - Mid-operation reset: assert BTN0=0 while AN=1011 -> next edge AN=1111, SEG=8'hFF.
//   After release the scan restarts at AN=1110.

Source files
------------

// File: rtl/vis_display.sv
// Shows the switch value as a 4-digit decimal on a multiplexed common-anode display.
// Optional feature: define VIS_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module vis_display #(
  parameter int DIV_W = 16
) (
  input  logic        F50MHz,
  input  logic        BTN0,
  input  logic [7:0]  SW,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic [7:0]  LED,
  output logic [15:0] dat
);

  logic [7:0]       sw_q;
  logic [15:0]      dat_q, dat_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       idx;
  logic [3:0]       nibble;
  logic             blank;
  logic [19:0]      dabble;
  logic [6:0]       code;

  assign idx   = cnt_q[DIV_W-1:DIV_W-2];
  assign cnt_d = cnt_q + 1'b1;

  // Double-dabble: three BCD digits sit above the 8 binary bits and are shifted in.
  always_comb begin
    dabble = {12'd0, sw_q};
    for (int i = 0; i < 8; i++) begin
      if (dabble[11:8]  >= 4'd5) dabble[11:8]  = dabble[11:8]  + 4'd3;
      if (dabble[15:12] >= 4'd5) dabble[15:12] = dabble[15:12] + 4'd3;
      if (dabble[19:16] >= 4'd5) dabble[19:16] = dabble[19:16] + 4'd3;
      dabble = dabble << 1;
    end
    dat_d = {4'h0, dabble[19:8]};
  end

  always_comb begin
    an_d   = 4'b1110;
    nibble = dat_q[3:0];
    blank  = 1'b0;
    case (idx)
      2'd0: begin
        an_d   = 4'b1110;
        nibble = dat_q[3:0];
      end
      2'd1: begin
        an_d   = 4'b1101;
        nibble = dat_q[7:4];
`ifdef VIS_LEADING_ZERO_BLANK_EN
        blank  = (dat_q[15:4] == 12'h000);
`endif
      end
      2'd2: begin
        an_d   = 4'b1011;
        nibble = dat_q[11:8];
`ifdef VIS_LEADING_ZERO_BLANK_EN
        blank  = (dat_q[15:8] == 8'h00);
`endif
      end
      default: begin
        an_d   = 4'b0111;
        nibble = dat_q[15:12];
`ifdef VIS_LEADING_ZERO_BLANK_EN
        blank  = (dat_q[15:12] == 4'h0);
`endif
      end
    endcase
  end

  // Active-low {g..a}; non-decimal nibbles go dark rather than showing garbage.
  always_comb begin
    code = 7'h7F;
    case (nibble)
      4'd0: code = 7'h40;
      4'd1: code = 7'h79;
      4'd2: code = 7'h24;
      4'd3: code = 7'h30;
      4'd4: code = 7'h19;
      4'd5: code = 7'h12;
      4'd6: code = 7'h02;
      4'd7: code = 7'h78;
      4'd8: code = 7'h00;
      4'd9: code = 7'h10;
      default: code = 7'h7F;
    endcase
    seg_d = blank ? 8'hFF : {1'b1, code};
  end

  always_ff @(posedge F50MHz) begin
    if (!BTN0) begin
      sw_q  <= 8'h00;
      dat_q <= 16'h0000;
      cnt_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= 8'hFF;
    end else begin
      sw_q  <= SW;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign LED = sw_q;
  assign dat = dat_q;

endmodule

// File: tb/tb_vis_display.sv
// Scoreboard bench for vis_display (DIV_W=4): stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_vis_display;

  localparam int DIV_W = 4;

  logic        clk = 1'b0;
  logic        btn0;
  logic [7:0]  sw;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [7:0]  led;
  logic [15:0] dat;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        expq[$];
  int          cycle   = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          relEdge = 0;
  logic [15:0] act;

  logic [3:0]  anTab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0]  swVec  [9] = '{8'h01, 8'h09, 8'h10, 8'h1A, 8'h1F, 8'h63, 8'h64, 8'hC8, 8'hFF};
  logic [15:0] datVec [9] = '{16'h0001, 16'h0009, 16'h0016, 16'h0026, 16'h0031,
                              16'h0099, 16'h0100, 16'h0200, 16'h0255};

  vis_display #(.DIV_W(DIV_W)) dut (
    .F50MHz(clk),
    .BTN0  (btn0),
    .SW    (sw),
    .AN    (an),
    .SEG   (seg),
    .LED   (led),
    .dat   (dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectAt(input int d, input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc  = cycle + d;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    expq.push_back(e);
  endtask

  // Scan phase k edges after the first edge out of reset selects anTab[(k/4)%4].
  function automatic int phaseAt(input int c);
    return ((c - relEdge) >> 2) & 3;
  endfunction

  task automatic scanCheck(input logic [31:0] segs, input string tag);
    for (int d = 1; d <= 16; d++) begin
      int p;
      p = phaseAt(cycle + d);
      expectAt(d, 0, {12'h000, anTab[p]}, {tag, " AN"});
      expectAt(d, 1, {8'h00, segs[p*8 +: 8]}, {tag, " SEG"});
    end
    repeat (16) step();
  endtask

  always @(negedge clk) begin
    for (int i = expq.size() - 1; i >= 0; i--) begin
      if (expq[i].cyc <= cycle) begin
        case (expq[i].kind)
          0:       act = {12'h000, an};
          1:       act = {8'h00, seg};
          2:       act = {8'h00, led};
          default: act = dat;
        endcase
        checks++;
        if (expq[i].cyc < cycle) begin
          errors++;
          $display("[TB] FAIL %s overdue: due cycle %0d, now %0d", expq[i].name, expq[i].cyc, cycle);
        end else if (act !== expq[i].val) begin
          errors++;
          $display("[TB] FAIL %s at cycle %0d: got %h expected %h", expq[i].name, cycle, act, expq[i].val);
        end
        expq.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    btn0 = 1'b0;
    sw   = 8'h00;
    expectAt(2, 0, 16'h000F, "reset AN");
    expectAt(2, 1, 16'h00FF, "reset SEG");
    expectAt(2, 2, 16'h0000, "reset LED");
    expectAt(2, 3, 16'h0000, "reset dat");
    step();
    step();

    btn0    = 1'b1;
    relEdge = cycle + 1;
    expectAt(1, 0, 16'h000E, "release AN");
    expectAt(1, 1, 16'h00C0, "release SEG");

    for (int v = 0; v < 9; v++) begin
      sw = swVec[v];
      expectAt(1, 2, {8'h00, swVec[v]}, "conv LED");
      expectAt(2, 3, datVec[v], "conv dat");
      step();
      step();
    end
    step();

`ifdef VIS_LEADING_ZERO_BLANK_EN
    scanCheck({8'hFF, 8'hA4, 8'h92, 8'h92}, "scan 255");
`else
    scanCheck({8'hC0, 8'hA4, 8'h92, 8'h92}, "scan 255");
`endif

    sw = 8'h09;
    repeat (3) step();
`ifdef VIS_LEADING_ZERO_BLANK_EN
    scanCheck({8'hFF, 8'hFF, 8'hFF, 8'h90}, "scan 9");
`else
    scanCheck({8'hC0, 8'hC0, 8'hC0, 8'h90}, "scan 9");
`endif

    found = 1'b0;
    for (int w = 0; w < 32 && !found; w++) begin
      if (phaseAt(cycle) == 2) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL midreset phase search: got none expected AN=1011 within 32 cycles");
    end

    btn0 = 1'b0;
    expectAt(1, 0, 16'h000F, "midreset AN");
    expectAt(1, 1, 16'h00FF, "midreset SEG");
    expectAt(1, 2, 16'h0000, "midreset LED");
    expectAt(1, 3, 16'h0000, "midreset dat");
    step();

    btn0    = 1'b1;
    relEdge = cycle + 1;
    for (int d = 1; d <= 8; d++)
      expectAt(d, 0, {12'h000, anTab[phaseAt(cycle + d)]}, "restart AN");
    expectAt(1, 2, 16'h0009, "restart LED");
    expectAt(1, 1, 16'h00C0, "restart SEG0");
    expectAt(2, 3, 16'h0009, "restart dat");
    expectAt(3, 1, 16'h0090, "restart SEG9");
    repeat (8) step();
    repeat (2) step();

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover expectations: got %0d expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
